// File: rtl/datapath_pkg.sv
// Shared datapath constants and the read-port state encoding for the register file.
package datapath_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_VALID = 1'b1
    } rd_state_e;

endpackage

// File: rtl/reg_array.sv
// Register storage with one synchronous write port and two combinational read ports.
module reg_array #(
    parameter int DATA_W  = datapath_pkg::DATA_W,
    parameter int ADDR_W  = datapath_pkg::ADDR_W,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data
);

    localparam int NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NumRegs];
    logic              w_wr_drop;

    // With a hardwired-zero R0, writes to address 0 are discarded.
    assign w_wr_drop = ZERO_R0 && (i_wr_addr == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && !w_wr_drop) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_ra_data = (ZERO_R0 && (i_ra_addr == '0)) ? '0 : r_regs[i_ra_addr];
    assign o_rb_data = (ZERO_R0 && (i_rb_addr == '0)) ? '0 : r_regs[i_rb_addr];

endmodule

// File: rtl/reg_file_rd.sv
// Register file with registered operand outputs, write-to-read bypass and stall coherence.
module reg_file_rd #(
    parameter int DATA_W  = datapath_pkg::DATA_W,
    parameter int ADDR_W  = datapath_pkg::ADDR_W,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic              i_stall,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data,
    output logic              o_rd_valid
);

    import datapath_pkg::*;

    logic [DATA_W-1:0] w_ra_stored;
    logic [DATA_W-1:0] w_rb_stored;
    logic [DATA_W-1:0] w_ra_next;
    logic [DATA_W-1:0] w_rb_next;
    logic              w_coh_a;
    logic              w_coh_b;

    logic [DATA_W-1:0] r_ra_data;
    logic [DATA_W-1:0] r_rb_data;
    logic [ADDR_W-1:0] r_la;
    logic [ADDR_W-1:0] r_lb;
    rd_state_e         r_state;

    // True when the in-flight write should be forwarded to a port reading address a.
    function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
        return i_wr_en && (i_wr_addr == a) && !(ZERO_R0 && (a == '0));
    endfunction

    reg_array #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_reg_array (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_ra_addr (i_ra_addr),
        .i_rb_addr (i_rb_addr),
        .o_ra_data (w_ra_stored),
        .o_rb_data (w_rb_stored)
    );

    assign w_ra_next = fwd_hit(i_ra_addr) ? i_wr_data : w_ra_stored;
    assign w_rb_next = fwd_hit(i_rb_addr) ? i_wr_data : w_rb_stored;
    assign w_coh_a   = fwd_hit(r_la);
    assign w_coh_b   = fwd_hit(r_lb);

    // Stall takes priority over capture; held operands still track writes to their latched address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ra_data <= '0;
            r_rb_data <= '0;
            r_la      <= '0;
            r_lb      <= '0;
            r_state   <= RD_IDLE;
        end else if (i_stall) begin
            if (w_coh_a) r_ra_data <= i_wr_data;
            if (w_coh_b) r_rb_data <= i_wr_data;
        end else if (i_rd_en) begin
            r_ra_data <= w_ra_next;
            r_rb_data <= w_rb_next;
            r_la      <= i_ra_addr;
            r_lb      <= i_rb_addr;
            r_state   <= RD_VALID;
        end else begin
            r_state   <= RD_IDLE;
        end
    end

    assign o_ra_data  = r_ra_data;
    assign o_rb_data  = r_rb_data;
    assign o_rd_valid = (r_state == RD_VALID);

endmodule

// File: tb/tb_reg_file_rd.sv
// Scoreboard bench for reg_file_rd: one ordinary build and one hardwired-zero-R0 build.
module tb_reg_file_rd;

    typedef struct {
        string       name;
        bit          sel;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        valid;
        bit          chk;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        rdEn, stall, wrEn;
    logic [3:0]  raAddr, rbAddr, wrAddr;
    logic [15:0] wrData;
    logic [15:0] raData, rbData;
    logic        rdValid;

    logic        zRdEn, zStall, zWrEn;
    logic [3:0]  zRaAddr, zRbAddr, zWrAddr;
    logic [15:0] zWrData;
    logic [15:0] zRaData, zRbData;
    logic        zRdValid;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    reg_file_rd #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b0)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_en    (rdEn),
        .i_stall    (stall),
        .i_ra_addr  (raAddr),
        .i_rb_addr  (rbAddr),
        .i_wr_en    (wrEn),
        .i_wr_addr  (wrAddr),
        .i_wr_data  (wrData),
        .o_ra_data  (raData),
        .o_rb_data  (rbData),
        .o_rd_valid (rdValid)
    );

    reg_file_rd #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1)) dutZero (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_en    (zRdEn),
        .i_stall    (zStall),
        .i_ra_addr  (zRaAddr),
        .i_rb_addr  (zRbAddr),
        .i_wr_en    (zWrEn),
        .i_wr_addr  (zWrAddr),
        .i_wr_data  (zWrData),
        .o_ra_data  (zRaData),
        .o_rb_data  (zRbData),
        .o_rd_valid (zRdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic driveIdle();
        rdEn = 0; stall = 0; wrEn = 0; raAddr = 0; rbAddr = 0; wrAddr = 0; wrData = 0;
        zRdEn = 0; zStall = 0; zWrEn = 0; zRaAddr = 0; zRbAddr = 0; zWrAddr = 0; zWrData = 0;
    endtask

    // Drives one cycle of inputs and queues what the selected DUT must show after the next edge.
    task automatic applyStimulus(input bit sel, input bit rEn, input bit st,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input bit wEn, input logic [3:0] wa, input logic [15:0] wd,
                                 input string name, input bit chk,
                                 input logic [15:0] eRa, input logic [15:0] eRb, input logic eV);
        exp_t e;
        @(posedge clk);
        #2;
        driveIdle();
        if (!sel) begin
            rdEn = rEn; stall = st; raAddr = ra; rbAddr = rb; wrEn = wEn; wrAddr = wa; wrData = wd;
        end else begin
            zRdEn = rEn; zStall = st; zRaAddr = ra; zRbAddr = rb; zWrEn = wEn; zWrAddr = wa; zWrData = wd;
        end
        e.name = name; e.sel = sel; e.ra = eRa; e.rb = eRb; e.valid = eV; e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic drainQueue();
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #3;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
        end
    endtask

    // Monitor: pops one expectation per edge and compares the addressed DUT's outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    checkOutput({e.name, ".ra"}, e.sel ? zRaData : raData, e.ra);
                    checkOutput({e.name, ".rb"}, e.sel ? zRbData : rbData, e.rb);
                    checkOutput({e.name, ".valid"}, {15'd0, e.sel ? zRdValid : rdValid}, {15'd0, e.valid});
                end
            end
        end
    end

    initial begin
        driveIdle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 1, 3, 16'h4AA2, "wr_r3",       1, 16'h0000, 16'h0000, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 16'hAF9C, "wr_r5",       1, 16'h0000, 16'h0000, 0);
        applyStimulus(0, 1, 0, 3, 5, 0, 0, 16'h0000, "basic",       1, 16'h4AA2, 16'hAF9C, 1);
        applyStimulus(0, 1, 0, 7, 3, 1, 7, 16'h1234, "bypass",      1, 16'h1234, 16'h4AA2, 1);
        applyStimulus(0, 1, 0, 3, 7, 0, 0, 16'h0000, "r7_stored",   1, 16'h4AA2, 16'h1234, 1);
        applyStimulus(0, 0, 1, 0, 0, 1, 3, 16'hBEEF, "stall_coh",   1, 16'hBEEF, 16'h1234, 1);
        applyStimulus(0, 0, 1, 0, 0, 1, 9, 16'h5555, "stall_other", 1, 16'hBEEF, 16'h1234, 1);
        applyStimulus(0, 1, 1, 5, 5, 0, 0, 16'h0000, "stall_block", 1, 16'hBEEF, 16'h1234, 1);
        applyStimulus(0, 1, 0, 5, 5, 0, 0, 16'h0000, "release",     1, 16'hAF9C, 16'hAF9C, 1);
        applyStimulus(0, 0, 0, 9, 9, 0, 0, 16'h0000, "idle",        1, 16'hAF9C, 16'hAF9C, 0);
        applyStimulus(0, 1, 1, 0, 0, 1, 5, 16'h7777, "idle_stall",  1, 16'h7777, 16'h7777, 0);
        applyStimulus(0, 1, 0, 9, 0, 0, 0, 16'h0000, "rd_r9_r0",    1, 16'h5555, 16'h0000, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 16'hA5A5, "r0_bypass",   1, 16'hA5A5, 16'hA5A5, 1);
        drainQueue();

        driveIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst.ra", raData, 16'h0000);
        checkOutput("async_rst.rb", rbData, 16'h0000);
        checkOutput("async_rst.valid", {15'd0, rdValid}, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 0, 4'(i), 4'(15 - i), 0, 0, 16'h0000,
                          $sformatf("rst_rd_%0d", i), 1, 16'h0000, 16'h0000, 1);
        end

        applyStimulus(1, 0, 0, 0, 0, 1, 0, 16'hFFFF, "z_wr_r0",     1, 16'h0000, 16'h0000, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 16'h0000, "z_rd_r0",     1, 16'h0000, 16'h0000, 1);
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 16'hFFFF, "z_bypass_r0", 1, 16'h0000, 16'h0000, 1);
        applyStimulus(1, 1, 0, 2, 0, 1, 2, 16'h1111, "z_bypass_r2", 1, 16'h1111, 16'h0000, 1);
        applyStimulus(1, 1, 0, 0, 2, 0, 0, 16'h0000, "z_capture",   1, 16'h0000, 16'h1111, 1);
        applyStimulus(1, 0, 1, 0, 0, 1, 0, 16'hFFFF, "z_coh_r0",    1, 16'h0000, 16'h1111, 1);
        applyStimulus(1, 0, 1, 0, 0, 1, 2, 16'h2222, "z_coh_r2",    1, 16'h0000, 16'h2222, 1);
        drainQueue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
